// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one single-cycle ALU between two
// requesters. Each operation runs IDLE -> EXEC -> RESP. The result is held in
// a per-requester slot until the winning requester takes it.

// Per-requester result holding register. It loads on the EXEC strobe and
// otherwise keeps its last value.
module alu_share_resp_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cap,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_zero,
  output logic [WIDTH-1:0] o_data,
  output logic             o_zero
);
  logic [WIDTH-1:0] r_data;
  logic             r_zero;

  // capture the ALU result when this slot's requester owns the EXEC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_zero <= 1'b0;
    end else if (i_cap) begin
      r_data <= i_data;
      r_zero <= i_zero;
    end
  end

  assign o_data = r_data;
  assign o_zero = r_zero;
endmodule

module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_req_valid,
  input  logic             r1_req_valid,
  output logic             r0_req_ready,
  output logic             r1_req_ready,
  input  logic [1:0]       r0_alu_op,
  input  logic [1:0]       r1_alu_op,
  input  logic [2:0]       r0_func3,
  input  logic [2:0]       r1_func3,
  input  logic [6:0]       r0_func7,
  input  logic [6:0]       r1_func7,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  output logic             r0_resp_valid,
  output logic             r1_resp_valid,
  input  logic             r0_resp_ready,
  input  logic             r1_resp_ready,
  output logic [WIDTH-1:0] r0_resp_data,
  output logic [WIDTH-1:0] r1_resp_data,
  output logic             r0_resp_zero,
  output logic             r1_resp_zero,
  output logic [1:0]       alu_operation,
  output logic [2:0]       alu_func3,
  output logic [6:0]       alu_func7,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_en,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
);
  localparam int NREQ = 2;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             gid;
  } opnd_t;

  state_t                      r_state, w_state_nxt;
  logic                        r_last_grant;
  opnd_t                       r_opnd;
  opnd_t [NREQ-1:0]            w_req;
  logic  [NREQ-1:0]            w_req_valid;
  logic  [NREQ-1:0]            w_resp_ready;
  logic  [NREQ-1:0]            w_grant;
  logic  [NREQ-1:0]            w_resp_valid;
  logic  [NREQ-1:0]            w_resp_zero;
  logic  [NREQ-1:0][WIDTH-1:0] w_resp_data;
  logic                        w_hs;
  logic                        w_exec;

  // Gather both requester channels into arrays so the rest of the block is
  // indexed by requester id.
  assign w_req[0] = '{op: r0_alu_op, f3: r0_func3, f7: r0_func7, a: r0_a, b: r0_b, gid: 1'b0};
  assign w_req[1] = '{op: r1_alu_op, f3: r1_func3, f7: r1_func7, a: r1_a, b: r1_b, gid: 1'b1};
  assign w_req_valid  = {r1_req_valid, r0_req_valid};
  assign w_resp_ready = {r1_resp_ready, r0_resp_ready};

  // Round-robin grant, offered only in IDLE. On a tie the requester that did
  // not win last time is preferred. A grant doubles as req_ready.
  always_comb begin
    w_grant = '0;
    if (r_state == IDLE) begin
      if (w_req_valid[0] && (!w_req_valid[1] || r_last_grant))
        w_grant[0] = 1'b1;
      else if (w_req_valid[1])
        w_grant[1] = 1'b1;
    end
  end

  assign w_hs   = |w_grant;
  assign w_exec = (r_state == EXEC);

  // next-state: one EXEC cycle, then hold RESP until the winner takes it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (w_resp_ready[r_opnd.gid]) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Operand register and grant history, loaded on the handshake. The last
  // grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opnd       <= '0;
      r_last_grant <= 1'b1;
    end else if (w_hs) begin
      r_opnd       <= w_req[w_grant[1]];
      r_last_grant <= w_grant[1];
    end
  end

  // One result slot per requester, so the loser's response outputs keep
  // their last value.
  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    alu_share_resp_slot #(.WIDTH(WIDTH)) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_cap  (w_exec && (r_opnd.gid == 1'(g))),
      .i_data (alu_result),
      .i_zero (alu_zero),
      .o_data (w_resp_data[g]),
      .o_zero (w_resp_zero[g])
    );
    assign w_resp_valid[g] = (r_state == RESP) && (r_opnd.gid == 1'(g));
  end

  assign r0_req_ready  = w_grant[0];
  assign r1_req_ready  = w_grant[1];
  assign r0_resp_valid = w_resp_valid[0];
  assign r1_resp_valid = w_resp_valid[1];
  assign r0_resp_data  = w_resp_data[0];
  assign r1_resp_data  = w_resp_data[1];
  assign r0_resp_zero  = w_resp_zero[0];
  assign r1_resp_zero  = w_resp_zero[1];

  // The ALU-facing fields come straight from the operand register. They are
  // only meaningful while alu_en is high.
  assign alu_operation = r_opnd.op;
  assign alu_func3     = r_opnd.f3;
  assign alu_func7     = r_opnd.f7;
  assign alu_a         = r_opnd.a;
  assign alu_b         = r_opnd.b;
  assign alu_en        = w_exec;
  assign busy          = (r_state != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter. A behavioural ALU closes the loop on alu_*.
// Accepted operations are queued with their expected result. A negedge
// monitor checks grants, EXEC fields, response timing and data against that
// queue.
module tb_alu_share_arbiter;
  localparam int W = 32;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         r0_req_valid = 0, r1_req_valid = 0, r0_req_ready, r1_req_ready;
  logic [1:0]   r0_alu_op = 0, r1_alu_op = 0;
  logic [2:0]   r0_func3 = 0, r1_func3 = 0;
  logic [6:0]   r0_func7 = 0, r1_func7 = 0;
  logic [W-1:0] r0_a = 0, r0_b = 0, r1_a = 0, r1_b = 0;
  logic         r0_resp_valid, r1_resp_valid, r0_resp_ready = 0, r1_resp_ready = 0;
  logic [W-1:0] r0_resp_data, r1_resp_data;
  logic         r0_resp_zero, r1_resp_zero;
  logic [1:0]   alu_operation;
  logic [2:0]   alu_func3;
  logic [6:0]   alu_func7;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         alu_en, alu_zero, busy;

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req_valid(r0_req_valid), .r1_req_valid(r1_req_valid),
    .r0_req_ready(r0_req_ready), .r1_req_ready(r1_req_ready),
    .r0_alu_op(r0_alu_op), .r1_alu_op(r1_alu_op),
    .r0_func3(r0_func3), .r1_func3(r1_func3),
    .r0_func7(r0_func7), .r1_func7(r1_func7),
    .r0_a(r0_a), .r0_b(r0_b), .r1_a(r1_a), .r1_b(r1_b),
    .r0_resp_valid(r0_resp_valid), .r1_resp_valid(r1_resp_valid),
    .r0_resp_ready(r0_resp_ready), .r1_resp_ready(r1_resp_ready),
    .r0_resp_data(r0_resp_data), .r1_resp_data(r1_resp_data),
    .r0_resp_zero(r0_resp_zero), .r1_resp_zero(r1_resp_zero),
    .alu_operation(alu_operation), .alu_func3(alu_func3), .alu_func7(alu_func7),
    .alu_a(alu_a), .alu_b(alu_b), .alu_en(alu_en),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  // Behavioural ALU: control decode plus core.
  function automatic logic [W-1:0] alu_fn(input logic [1:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      2'b00: return a + b;
      2'b01: return a - b;
      2'b10: begin
        case (f3)
          3'b000:  return f7[5] ? a - b : a + b;
          3'b111:  return a & b;
          3'b110:  return a | b;
          3'b100:  return a ^ b;
          default: return a + b;
        endcase
      end
      default: return a + b;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_operation, alu_func3, alu_func7, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, W'(act), W'(exp));
  endtask

  typedef struct {
    logic         gid;
    logic [1:0]   op;
    logic [2:0]   f3;
    logic [6:0]   f7;
    logic [W-1:0] a, b, res;
    logic         z;
    int           hs;   // cycle number of the EXEC cycle
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e, m_n;
  logic m_last = 1'b1, m_inf, m_any, m_w, m_v0, m_v1;

  // Monitor / scoreboard: every negedge, compare DUT outputs with the queue
  // of accepted operations.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_last = 1'b1;
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_alu_en", alu_en, 1'b0);
      chk1("rst_r0_resp_valid", r0_resp_valid, 1'b0);
      chk1("rst_r1_resp_valid", r1_resp_valid, 1'b0);
      chk("rst_alu_ab", alu_a | alu_b, '0);
      chk("rst_alu_ctl", W'({alu_operation, alu_func3, alu_func7}), '0);
      chk("rst_resp_data", r0_resp_data | r1_resp_data, '0);
      chk1("rst_resp_zero", r0_resp_zero | r1_resp_zero, 1'b0);
    end else begin
      m_inf = (exp_q.size() != 0);
      if (m_inf) m_e = exp_q[0];
      chk1("busy", busy, m_inf);
      if (m_inf && cyc == m_e.hs) begin
        chk1("exec_alu_en", alu_en, 1'b1);
        chk("exec_op", W'(alu_operation), W'(m_e.op));
        chk("exec_f3", W'(alu_func3), W'(m_e.f3));
        chk("exec_f7", W'(alu_func7), W'(m_e.f7));
        chk("exec_a", alu_a, m_e.a);
        chk("exec_b", alu_b, m_e.b);
      end else begin
        chk1("alu_en_low", alu_en, 1'b0);
      end
      m_v0 = m_inf && !m_e.gid && (cyc > m_e.hs);
      m_v1 = m_inf && m_e.gid && (cyc > m_e.hs);
      chk1("r0_resp_valid", r0_resp_valid, m_v0);
      chk1("r1_resp_valid", r1_resp_valid, m_v1);
      if (m_v0 && r0_resp_valid) begin
        chk("r0_resp_data", r0_resp_data, m_e.res);
        chk1("r0_resp_zero", r0_resp_zero, m_e.z);
        if (r0_resp_ready) void'(exp_q.pop_front());
      end else if (m_v1 && r1_resp_valid) begin
        chk("r1_resp_data", r1_resp_data, m_e.res);
        chk1("r1_resp_zero", r1_resp_zero, m_e.z);
        if (r1_resp_ready) void'(exp_q.pop_front());
      end
      // Arbitration: a lone requester wins; a tie goes to the one not
      // granted last time; nothing is granted while an operation is in flight.
      m_any = r0_req_valid || r1_req_valid;
      m_w   = (r0_req_valid && r1_req_valid) ? !m_last : r1_req_valid;
      chk1("r0_req_ready", r0_req_ready, !m_inf && m_any && !m_w);
      chk1("r1_req_ready", r1_req_ready, !m_inf && m_any && m_w);
      if ((r0_req_valid && r0_req_ready) || (r1_req_valid && r1_req_ready)) begin
        m_n.gid = !(r0_req_valid && r0_req_ready);
        m_n.op  = m_n.gid ? r1_alu_op : r0_alu_op;
        m_n.f3  = m_n.gid ? r1_func3  : r0_func3;
        m_n.f7  = m_n.gid ? r1_func7  : r0_func7;
        m_n.a   = m_n.gid ? r1_a      : r0_a;
        m_n.b   = m_n.gid ? r1_b      : r0_b;
        m_n.res = alu_fn(m_n.op, m_n.f3, m_n.f7, m_n.a, m_n.b);
        m_n.z   = (m_n.res == '0);
        m_n.hs  = cyc + 1;
        m_last  = m_n.gid;
        exp_q.push_back(m_n);
      end
    end
  end

  logic acc0, acc1, t_g;
  int   t_last_g, t_last_c;
  logic [W-1:0] t_d;
  logic         t_z;

  // One cycle: sample the handshakes at negedge, then return just after posedge.
  task automatic step();
    @(negedge clk);
    acc0 = rst_n && r0_req_valid && r0_req_ready;
    acc1 = rst_n && r1_req_valid && r1_req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic [1:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [W-1:0] a, input logic [W-1:0] b);
    if (n == 0) begin
      r0_alu_op = op; r0_func3 = f3; r0_func7 = f7; r0_a = a; r0_b = b; r0_req_valid = 1'b1;
    end else begin
      r1_alu_op = op; r1_func3 = f3; r1_func7 = f7; r1_a = a; r1_b = b; r1_req_valid = 1'b1;
    end
  endtask

  task automatic rand_req(input int n);
    logic [2:0]   f3s [4] = '{3'b000, 3'b111, 3'b110, 3'b100};
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    set_req(n, 2'($urandom_range(0, 2)), f3s[$urandom_range(0, 3)],
            ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, a, b);
  endtask

  task automatic wait_acc(input int n);
    for (int i = 0; i < 20; i++) begin
      step();
      if ((n == 0) ? acc0 : acc1) return;
    end
    n_chk++; n_fail++;
    $display("FAIL wait_acc: requester %0d got no handshake within 20 cycles", n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk1("idle_r0_ready_novalid", r0_req_ready, 1'b0);
    chk1("idle_r1_ready_novalid", r1_req_ready, 1'b0);
    @(posedge clk); #1;

    // single add from r0
    r0_resp_ready = 1'b1; r1_resp_ready = 1'b1;
    set_req(0, 2'b00, 3'b000, 7'h00, 32'd5, 32'd3);
    wait_acc(0);
    r0_req_valid = 1'b0;
    @(negedge clk);
    chk1("add_alu_en", alu_en, 1'b1);
    chk("add_alu_op", W'(alu_operation), '0);
    chk("add_alu_a", alu_a, 32'd5);
    chk("add_alu_b", alu_b, 32'd3);
    @(negedge clk);
    chk1("add_resp_valid", r0_resp_valid, 1'b1);
    chk("add_resp_data", r0_resp_data, 32'd8);
    chk1("add_resp_zero", r0_resp_zero, 1'b0);
    chk1("add_r1_resp_valid", r1_resp_valid, 1'b0);
    @(posedge clk); #1;

    // tie: both requesters always valid; grants alternate, 3 cycles apart
    rand_req(0); rand_req(1);
    t_last_g = -1; t_last_c = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (acc0 || acc1) begin
        t_g = acc1;
        if (t_last_g >= 0) begin
          chk("tie_alternate", W'(t_g), W'(t_last_g == 0));
          chk("tie_spacing", W'(cyc - t_last_c), 32'd3);
        end
        t_last_g = int'(t_g);
        t_last_c = cyc;
        rand_req(int'(t_g));
      end
    end
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    repeat (4) step();

    // R-type subtract giving zero, from r1
    set_req(1, 2'b10, 3'b000, 7'b0100000, 32'd7, 32'd7);
    wait_acc(1);
    r1_req_valid = 1'b0;
    @(negedge clk);
    chk("sub_alu_func7", W'(alu_func7), 32'h20);
    @(negedge clk);
    chk1("sub_resp_valid", r1_resp_valid, 1'b1);
    chk("sub_resp_data", r1_resp_data, '0);
    chk1("sub_resp_zero", r1_resp_zero, 1'b1);
    @(posedge clk); #1;

    // backpressure on r0 with an r1 request pending
    r0_resp_ready = 1'b0;
    set_req(0, 2'b00, 3'b000, 7'h00, 32'h1234, 32'h0f0f);
    wait_acc(0);
    r0_req_valid = 1'b0;
    set_req(1, 2'b01, 3'b000, 7'h00, 32'd9, 32'd4);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    t_d = r0_resp_data; t_z = r0_resp_zero;
    for (int i = 0; i < 4; i++) begin
      chk1("bp_resp_valid", r0_resp_valid, 1'b1);
      chk("bp_resp_data_stable", r0_resp_data, t_d);
      chk1("bp_resp_zero_stable", r0_resp_zero, t_z);
      chk1("bp_r1_req_ready", r1_req_ready, 1'b0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    r0_resp_ready = 1'b1;
    step();
    step();
    chk1("bp_r1_accept_next", acc1, 1'b1);
    r1_req_valid = 1'b0;
    repeat (4) step();

    // reset asserted during EXEC
    set_req(0, 2'b00, 3'b000, 7'h00, 32'd100, 32'd23);
    wait_acc(0);
    r0_req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk1("rst_exec_busy", busy, 1'b0);
    chk1("rst_exec_alu_en", alu_en, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step();
    set_req(0, 2'b01, 3'b000, 7'h00, 32'd50, 32'd8);
    wait_acc(0);
    r0_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk1("post_rst_resp_valid", r0_resp_valid, 1'b1);
    chk("post_rst_resp_data", r0_resp_data, 32'd42);
    @(posedge clk); #1;

    // random traffic with withdrawals and response backpressure
    for (int i = 0; i < 500; i++) begin
      step();
      r0_resp_ready = ($urandom_range(0, 3) != 0);
      r1_resp_ready = ($urandom_range(0, 3) != 0);
      if (acc0) r0_req_valid = 1'b0;
      else if (r0_req_valid && $urandom_range(0, 15) == 0) r0_req_valid = 1'b0;
      if (acc1) r1_req_valid = 1'b0;
      else if (r1_req_valid && $urandom_range(0, 15) == 0) r1_req_valid = 1'b0;
      if (!r0_req_valid && $urandom_range(0, 2) == 0) rand_req(0);
      if (!r1_req_valid && $urandom_range(0, 2) == 0) rand_req(1);
    end
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    r0_resp_ready = 1'b1; r1_resp_ready = 1'b1;
    repeat (6) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequencer and arbiter that shares the single-cycle ALU (ALU control decoder plus ALU core) between two requesters, such as the integer pipe and the address-generation unit. Each requester presents one operation with a valid/ready handshake. The block grants the ALU round-robin, drives the decoder inputs and operands for exactly one cycle, and captures the result. It then returns the result on the winner's response channel. It sits between the requesters and the shared `ALUControl`/ALU instance.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `r0_req_valid`, `r1_req_valid` input 1: requester has an operation.
- `r0_req_ready`, `r1_req_ready` output 1: the operation is accepted this cycle.
- `r0_alu_op`, `r1_alu_op` input 2: ALU operation code (00 add, 01 sub, 10 R-type decode).
- `r0_func3`, `r1_func3` input 3: func3 field.
- `r0_func7`, `r1_func7` input 7: func7 field.
- `r0_a`, `r0_b`, `r1_a`, `r1_b` input WIDTH: operands.
- `r0_resp_valid`, `r1_resp_valid` output 1: result available.
- `r0_resp_ready`, `r1_resp_ready` input 1: requester takes the result.
- `r0_resp_data`, `r1_resp_data` output WIDTH: captured ALU result.
- `r0_resp_zero`, `r1_resp_zero` output 1: captured zero flag.
- `alu_operation` output 2: to the ALU control decoder.
- `alu_func3` output 3: to the ALU control decoder.
- `alu_func7` output 7: to the ALU control decoder.
- `alu_a`, `alu_b` output WIDTH: to the ALU core.
- `alu_en` output 1: ALU strobe, high only in EXEC.
- `alu_result` input WIDTH: combinational ALU result.
- `alu_zero` input 1: combinational ALU zero flag.
- `busy` output 1: state is not IDLE.

## Operation
- FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - `rN_req_ready` is high only for the granted requester. It is combinational from state, `last_grant` and the other requester's valid.
  - With one valid requester, that requester is granted.
  - With both valid, the requester not equal to `last_grant` is granted.
  - The handshake is `req_valid && req_ready`. On handshake the block latches alu_op, func3, func7, a, b and `grant_id` into the operand register, sets `last_grant = grant_id`, and moves to EXEC.
  - No valid requester: stay in IDLE.
- EXEC, one cycle:
  - `alu_en` is high.
  - `alu_*` outputs drive the latched fields.
  - At the clock edge, `alu_result` and `alu_zero` are captured into the result register, and the state moves to RESP.
- RESP:
  - `rN_resp_valid` is high for `grant_id` only; the other requester's resp_valid stays low.
  - resp_data and resp_zero stay stable until `rN_resp_ready` is high at a clock edge. Then the state moves to IDLE.
- Both `req_ready` outputs are low in EXEC and RESP. At most one operation is in flight.
- `alu_*` outputs hold the last latched value outside EXEC. Consumers qualify them with `alu_en`.
- The non-granted requester's `resp_data` and `resp_zero` outputs hold their last value.
- Operands pass through unmodified. No width extension or arithmetic is done in this block.

## Timing
- Reset values:
  - state IDLE, `last_grant` = 1 (requester 0 wins the first tie).
  - All `alu_*` outputs, `alu_en`, `busy`, `resp_valid`, `resp_data`, `resp_zero` and `req_ready` are 0, except the IDLE-derived `req_ready`.
- Latency: handshake at edge T; EXEC in cycle T+1; `resp_valid` high in cycle T+2.
- Throughput: with resp_ready held high, one operation every 3 cycles. Handshake at T, response taken at T+2, next handshake at the earliest at T+3.
- A requester dropping `req_valid` in IDLE before the handshake is legal and nothing is latched. Requesters must keep their fields stable while valid and not ready.
- A requester asserting `resp_ready` while its `resp_valid` is low has no effect.
- Reset asserted mid-operation, in EXEC or RESP:
  - The state returns to IDLE immediately (asynchronous) and the pending result is discarded.
  - No `resp_valid` is issued for that operation after release.
- A new request arriving during RESP waits; it is arbitrated in the following IDLE cycle.

## Test plan
- Reset check: hold `rst_n` low, then release → all outputs 0; `r0_req_ready` = 1 only once `r0_req_valid` = 1.
- Single add: r0 sends op=00, a=5, b=3 at T → at T+1, alu_en=1, alu_operation=00, alu_a=5, alu_b=3; at T+2, r0_resp_valid=1, r0_resp_data=8, r0_resp_zero=0. r1_resp_valid stays 0 throughout.
- Tie arbitration: both requesters valid continuously, resp_ready held high → handshakes alternate r0, r1, r0, r1, spaced 3 cycles apart.
- Subtract with zero: r1 sends op=10, func3=000, func7=0100000, a=b=7 → alu_func7=0100000 in EXEC; r1_resp_data=0 and r1_resp_zero=1.
- Backpressure: r0_resp_ready low for 4 cycles in RESP → resp_valid, resp_data and resp_zero stable; both req_ready=0; a pending r1 request is accepted the cycle after r0's response is taken.
- Reset during EXEC: assert `rst_n` low in the EXEC cycle → state IDLE and outputs 0 at once; after release, no stale resp_valid appears, and a new r0 request completes with normal 2-cycle latency.
